// File: rtl/uart_transceiver.sv
`timescale 1ns/1ps
// uart_transceiver: 8N1 UART transmitter and receiver; define UART_RX_SYNC_EN to pass SIn through a 2-flop synchronizer
module uart_transceiver #(
  parameter int ClockFreq = 100_000_000,
  parameter int BaudRate = 115_200
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] DataIn,
  input  logic       DataInValid,
  output logic       DataInReady,
  output logic [7:0] DataOut,
  output logic       DataOutValid,
  input  logic       DataOutReady,
  input  logic       SIn,
  output logic       SOut
);
  localparam int N = ClockFreq / BaudRate;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LastCnt = CW'(N - 1);
  localparam logic [CW-1:0] HalfCnt = CW'(N / 2 - 1);
  typedef enum logic [1:0] {Idle, Start, Data, Stop} stateT;
  stateT rxState, rxNext, txState, txNext;
  logic [CW-1:0] rxCnt, txCnt;
  logic [2:0] rxBit, txBit;
  logic [7:0] rxShift, txShift;
  logic rxIn, rxPrev, rxTick, txTick;
`ifdef UART_RX_SYNC_EN
  logic [1:0] rxSync;
  // two-flop synchronizer, idles high so reset does not look like a start bit
  always_ff @(posedge Clock)
    rxSync <= Reset ? 2'b11 : {rxSync[0], SIn};
  assign rxIn = rxSync[1];
`else
  assign rxIn = SIn;
`endif
  // receiver next state: start is re-checked at half a bit, data and stop at bit centres
  always_comb begin
    rxTick = rxCnt == (rxState == Start ? HalfCnt : LastCnt);
    rxNext = rxState;
    case (rxState)
      Idle:    rxNext = (rxPrev && !rxIn) ? Start : Idle;
      Start:   rxNext = rxTick ? (rxIn ? Idle : Data) : Start;
      Data:    rxNext = (rxTick && rxBit == 3'd7) ? Stop : Data;
      default: rxNext = rxTick ? Idle : Stop;
    endcase
  end
  // receiver datapath: shift in LSB first, deliver only good frames into an empty holding register
  always_ff @(posedge Clock)
    if (Reset) begin
      rxState <= Idle;
      rxCnt <= '0;
      rxBit <= '0;
      rxShift <= '0;
      rxPrev <= 1'b1;
      DataOut <= '0;
      DataOutValid <= 1'b0;
    end else begin
      rxState <= rxNext;
      rxPrev <= rxIn;
      rxCnt <= (rxState == Idle || rxTick) ? '0 : rxCnt + 1'b1;
      if (rxState == Start) rxBit <= '0;
      if (rxState == Data && rxTick) begin
        rxShift <= {rxIn, rxShift[7:1]};
        rxBit <= rxBit + 1'b1;
      end
      if (rxState == Stop && rxTick && rxIn && !DataOutValid) begin
        DataOut <= rxShift;
        DataOutValid <= 1'b1;
      end else if (DataOutReady) DataOutValid <= 1'b0;
    end
  // transmitter next state: every bit, including start and stop, lasts N cycles
  always_comb begin
    txTick = txCnt == LastCnt;
    DataInReady = txState == Idle;
    txNext = txState;
    case (txState)
      Idle:    txNext = DataInValid ? Start : Idle;
      Start:   txNext = txTick ? Data : Start;
      Data:    txNext = (txTick && txBit == 3'd7) ? Stop : Data;
      default: txNext = txTick ? Idle : Stop;
    endcase
  end
  // transmitter datapath: SOut is registered and updated one step ahead of each bit boundary
  always_ff @(posedge Clock)
    if (Reset) begin
      txState <= Idle;
      txCnt <= '0;
      txBit <= '0;
      txShift <= '0;
      SOut <= 1'b1;
    end else begin
      txState <= txNext;
      txCnt <= (txState == Idle || txTick) ? '0 : txCnt + 1'b1;
      if (txState == Idle && DataInValid) begin
        txShift <= DataIn;
        txBit <= '0;
        SOut <= 1'b0;
      end
      if (txTick && txState == Start) begin
        SOut <= txShift[0];
        txShift <= txShift >> 1;
      end
      if (txTick && txState == Data) begin
        SOut <= txBit == 3'd7 ? 1'b1 : txShift[0];
        txShift <= txShift >> 1;
        txBit <= txBit + 1'b1;
      end
    end
endmodule

// File: tb/tb_uart_transceiver.sv
`timescale 1ns/1ps
// tb_uart_transceiver: directed and randomized frames against a byte-level model of the UART
module tb_uart_transceiver;
  localparam int N = 868;
  localparam int H = N / 2;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic [7:0] DataIn = '0;
  logic DataInValid = 1'b0;
  logic DataInReady;
  logic [7:0] DataOut;
  logic DataOutValid;
  logic DataOutReady = 1'b0;
  logic sinTb = 1'b1;
  logic loopBack = 1'b0;
  logic SIn;
  logic SOut;
  int passCount = 0;
  int checkCount = 0;
  logic modelValid = 1'b0;
  logic [7:0] modelData = '0;
  logic [7:0] r1, r2, r3, rb;
  assign SIn = loopBack ? SOut : sinTb;
  always #5 Clock = ~Clock;
  uart_transceiver dut (
    .Clock(Clock), .Reset(Reset), .DataIn(DataIn), .DataInValid(DataInValid),
    .DataInReady(DataInReady), .DataOut(DataOut), .DataOutValid(DataOutValid),
    .DataOutReady(DataOutReady), .SIn(SIn), .SOut(SOut)
  );
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge Clock);
  endtask
  task automatic checkRx(input string tag);
    check({tag, "Valid"}, DataOutValid, modelValid);
    check({tag, "Data"}, DataOut, modelData);
  endtask
  task automatic sendRx(input logic [7:0] b, input logic stopBit);
    logic [9:0] f;
    f = {stopBit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      sinTb = f[i];
      cycles(N);
    end
    sinTb = 1'b1;
    if (stopBit && !modelValid) begin
      modelValid = 1'b1;
      modelData = b;
    end
  endtask
  task automatic release1();
    DataOutReady = 1'b1;
    cycles(1);
    DataOutReady = 1'b0;
    modelValid = 1'b0;
    check("releaseValid", DataOutValid, 0);
  endtask
  task automatic sendTx(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    check("txReadyIdle", DataInReady, 1);
    DataIn = b;
    DataInValid = 1'b1;
    cycles(1);
    DataInValid = 1'b0;
    DataIn = ~b;
    check("txReadyBusy", DataInReady, 0);
    check("txStartEdge", SOut, 0);
    cycles(H);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("txBit%0d", i), SOut, f[i]);
      if (i < 9) cycles(N);
    end
    cycles(H - 1);
    check("txStopEndBusy", DataInReady, 0);
    check("txStopEndLine", SOut, 1);
    cycles(1);
    check("txReadyAgain", DataInReady, 1);
  endtask
  initial begin
    #1_500_000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    cycles(1);
    check("rstSOut", SOut, 1);
    check("rstReady", DataInReady, 1);
    checkRx("rst");
    cycles(4);
    Reset = 1'b0;
    cycles(3);
    sendRx(8'h21, 1'b1);
    checkRx("rx21");
    check("rx21Const", DataOut, 8'h21);
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      checkRx($sformatf("hold%0d", i));
      check($sformatf("holdSOut%0d", i), SOut, 1);
    end
    release1();
    r1 = 8'($urandom);
    r2 = r1 ^ 8'($urandom_range(1, 255));
    sendRx(r1, 1'b1);
    checkRx("rxRand");
    sendRx(r2, 1'b1);
    checkRx("overrun");
    release1();
    sendRx(8'($urandom), 1'b0);
    cycles(5);
    checkRx("framing");
    sinTb = 1'b0;
    cycles(300);
    sinTb = 1'b1;
    cycles(N);
    checkRx("glitch");
    r3 = 8'($urandom);
    sendRx(r3, 1'b1);
    checkRx("afterGlitch");
    release1();
    sendTx(8'h55);
    checkRx("txOnly");
    rb = 8'($urandom);
    DataIn = 8'($urandom);
    DataInValid = 1'b1;
    cycles(1);
    DataInValid = 1'b0;
    for (int c = 0; c < 4 * N; c++) begin
      sinTb = c < N ? 1'b0 : rb[c / N - 1];
      cycles(1);
    end
    check("midTxBusy", DataInReady, 0);
    Reset = 1'b1;
    sinTb = 1'b1;
    cycles(1);
    modelValid = 1'b0;
    modelData = 8'h00;
    check("midRstSOut", SOut, 1);
    check("midRstReady", DataInReady, 1);
    checkRx("midRst");
    Reset = 1'b0;
    cycles(N);
    check("postRstSOut", SOut, 1);
    check("postRstReady", DataInReady, 1);
    cycles(7 * N);
    checkRx("postRst");
    loopBack = 1'b1;
    sendTx(8'hA5);
    modelValid = 1'b1;
    modelData = 8'hA5;
    checkRx("loopA5");
    release1();
    rb = 8'($urandom);
    sendTx(rb);
    modelValid = 1'b1;
    modelData = rb;
    checkRx("loopRand");
    release1();
    loopBack = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/uart_transceiver.md
UART_TRANSCEIVER -- requirements
Module: uart_transceiver

Interface
REQ-001 SHALL have parameter ClockFreq, default 100_000_000, meaning the Clock frequency in Hz.
REQ-002 SHALL have parameter BaudRate, default 115_200, meaning the serial bit rate in bits/s.
REQ-003 SHALL have port Clock, input, 1 bit: the single clock; all logic rising-edge.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port DataIn, input, 8 bits: byte to transmit.
REQ-006 SHALL have port DataInValid, input, 1 bit: DataIn is valid.
REQ-007 SHALL have port DataInReady, output, 1 bit: transmitter can accept a byte.
REQ-008 SHALL have port DataOut, output, 8 bits: last received byte.
REQ-009 SHALL have port DataOutValid, output, 1 bit: DataOut holds an unconsumed byte.
REQ-010 SHALL have port DataOutReady, input, 1 bit: consumer accepts DataOut.
REQ-011 SHALL have port SIn, input, 1 bit: serial receive line, idle high.
REQ-012 SHALL have port SOut, output, 1 bit: serial transmit line, idle high.

Function
REQ-013 SHALL use bit period N = ClockFreq/BaudRate cycles (integer division; 868 at defaults), with counters sized by $clog2(N+1).
REQ-014 SHALL use frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-015 RX SHALL detect a start on SIn high-to-low while idle and re-sample at N/2; if SIn is 1 there, it SHALL abort to idle.
REQ-016 RX SHALL then sample each data bit and the stop bit every N cycles, at bit centre.
REQ-017 RX SHALL load DataOut and set DataOutValid on the cycle after a stop bit sampled 1.
REQ-018 RX SHALL discard the byte and leave DataOut/DataOutValid unchanged when the stop bit is sampled 0 (framing error).
REQ-019 RX SHALL hold DataOut stable while DataOutValid=1 and DataOutReady=0, for any duration.
REQ-020 SHALL clear DataOutValid the cycle after DataOutValid&&DataOutReady.
REQ-021 RX SHALL drop a new byte that completes while DataOutValid=1 (overrun); the old byte is retained.
REQ-022 RX SHALL keep receiving the next frame while DataOutValid=1.
REQ-023 TX states SHALL be IDLE -> START -> DATA(8 bits) -> STOP -> IDLE, each bit lasting N cycles.
REQ-024 DataInReady SHALL be 1 only in IDLE.
REQ-025 DataInValid&&DataInReady SHALL latch DataIn, and SOut SHALL go 0 the next cycle.
REQ-026 DataIn changes after acceptance SHALL have no effect on the frame in flight.
REQ-027 SOut SHALL be registered (glitch-free) and SHALL be 1 in IDLE and STOP.
REQ-028 DataInReady SHALL return to 1 on the cycle after the stop bit's N cycles end.
REQ-029 TX and RX SHALL operate fully independently and concurrently.

Reset
REQ-030 On Reset=1 at a clock edge, the block SHALL set SOut=1, DataInReady=1, DataOutValid=0 and DataOut=8'h00.
REQ-031 On Reset=1 at a clock edge, both state machines SHALL go to IDLE and all counters SHALL clear.
REQ-032 Reset mid-frame SHALL abandon that frame with no partial byte delivered.
REQ-033 After Reset deasserts, RX SHALL wait for a fresh falling edge on SIn.

Configuration
REQ-034 When macro UART_RX_SYNC_EN is defined, SIn SHALL pass through a 2-flop synchronizer (reset value 1) before RX logic, adding 2 cycles RX latency.
REQ-035 When UART_RX_SYNC_EN is undefined, SIn SHALL feed RX logic directly.
REQ-036 All other behaviour SHALL be identical with or without UART_RX_SYNC_EN.

Verification
REQ-037 Receive: Reset 5 cycles, SIn idle 1, then frame for 0x21 (bits 1,0,0,0,0,1,0,0) at 8680 ns/bit -> DataOutValid=1, DataOut=0x21.
REQ-038 Hold: continuing REQ-037 with DataOutReady=0 for 10 cycles -> DataOut=0x21 and DataOutValid=1 throughout, SOut=1.
REQ-039 Release: continuing REQ-038, DataOutReady=1 for 1 cycle -> DataOutValid=0 next cycle.
REQ-040 Transmit: DataIn=0x55 with DataInValid=1 for 1 cycle in IDLE -> DataInReady=0, SOut = 0,1,0,1,0,1,0,1,0,1 each 868 cycles, then DataInReady=1.
REQ-041 Errors: stop bit 0 -> no DataOutValid; SIn low pulse shorter than 400 cycles -> no reception.
REQ-042 Reset mid-frame and loopback: Reset mid-frame -> SOut=1, no output byte; with SOut tied to SIn, sending 0xA5 -> receives 0xA5.
